// File: rtl/plc_apb_master.sv
// plc_apb_master: APB3 master for the PLC peripheral segment.
// It takes one read/write command at a time over valid/ready and runs it as a
// single SETUP+ACCESS transfer. The result goes back on a valid/ready response
// channel. A slave that holds PREADY low too long is aborted with rsp_err.
module plc_apb_master #(
    parameter int          szerokosc        = 32,
    parameter int          szerokosc_adresu = 16,
    parameter int unsigned TIMEOUT          = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    // command channel
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [szerokosc_adresu-1:0] req_addr,
    input  logic [szerokosc-1:0]        req_wdata,
    // response channel
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [szerokosc-1:0]        rsp_rdata,
    output logic                        rsp_err,
    // APB3
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [szerokosc_adresu-1:0] PADDR,
    output logic [szerokosc-1:0]        PWDATA,
    input  logic [szerokosc-1:0]        PRDATA,
    input  logic                        PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t      state, state_nx;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;
    logic        accept;
    logic        timeout_hit;

    // A new command may enter from IDLE, or from RESP on the same edge that
    // the previous response is consumed. This gives a 3-cycle period.
    assign req_ready   = PRESETn & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign accept      = req_valid & req_ready;

    // Saturating wait counter. The abort fires on the edge where the count
    // would reach the limit, so PREADY=0 over TIMEOUT ACCESS cycles aborts.
    assign wait_inc    = (&wait_cnt) ? wait_cnt : wait_cnt + 16'd1;
    assign timeout_hit = (TIMEOUT != 0) && (wait_inc >= TO_LIM);

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nx = RESP;
            RESP: begin
                if (accept)         state_nx = SETUP;
                else if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered APB outputs, request fields, wait counter and response data.
    // APB controls are decoded from the next state, so they come straight off
    // flops. An asynchronous reset drops them at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wait_cnt  <= '0;
        end else begin
            PSEL      <= (state_nx == SETUP) || (state_nx == ACCESS);
            PENABLE   <= (state_nx == ACCESS);
            rsp_valid <= (state_nx == RESP);
            if (accept) begin
                PWRITE   <= req_write;
                PADDR    <= req_addr;
                PWDATA   <= req_write ? req_wdata : '0;
                wait_cnt <= '0;
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata <= PWRITE ? '0 : PRDATA;
                    rsp_err   <= 1'b0;
                end else begin
                    wait_cnt <= wait_inc;
                    if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_plc_apb_master.sv
// Directed bench for plc_apb_master. The bench has a simple APB slave model
// with programmable wait states and a stuck-low PREADY option. It keeps a
// scoreboard of expected responses that is popped on every response handshake.
module tb_plc_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [15:0] PADDR;
    logic [31:0] PWDATA, PRDATA;

    int nvec = 0;
    int nmis = 0;

    // slave model controls
    int          waits = 0;
    logic        stuck = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          acc_cnt = 0;

    // monitor state
    logic [32:0] exp_q[$];
    int          psel_cnt = 0;
    int          pen_cnt  = 0;
    int          rsp_cnt  = 0;
    time         rsp_t_last = 0;
    logic        rv_prev = 1'b0;

    plc_apb_master #(.szerokosc(32), .szerokosc_adresu(16), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave: ready after 'waits' ACCESS cycles unless stuck
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end
    assign PREADY = PSEL & PENABLE & ~stuck & (acc_cnt >= waits);
    assign PRDATA = slave_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: APB activity counters, response timing, scoreboard compare
    always @(negedge PCLK) begin
        if (PENABLE) check("penable_without_psel", PSEL, 1'b1);
        if (PSEL)    psel_cnt++;
        if (PENABLE) pen_cnt++;
        if (rsp_valid && !rv_prev) begin
            rsp_cnt++;
            rsp_t_last = $time - 5;
        end
        rv_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_err", rsp_err, e[32]);
            end
        end
    end

    // Present a command and wait (bounded) for its acceptance edge
    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d, output time t_acc);
        int n;
        n = 0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 1'b0, 1'b1);
            req_valid = 1'b0;
            t_acc = 0;
            return;
        end
        @(posedge PCLK);
        t_acc = $time;
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) until the response count reaches target
    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 300) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (rsp_cnt < target) check("rsp_wait_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        time t;
        time ta[4];
        int  p0, e0, n0;

        PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // reset state
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 16'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_req_ready", req_ready, 1'b0);
        PRESETn = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1'b1);
        p0 = psel_cnt;
        repeat (20) @(posedge PCLK);
        #1;
        check("idle_no_psel", psel_cnt - p0, 0);

        // zero-wait write
        p0 = psel_cnt; e0 = pen_cnt; n0 = rsp_cnt;
        exp_q.push_back({1'b0, 32'h0});
        send(1'b1, 16'h0024, 32'h0000_0005, t);
        check("wr_setup_psel", PSEL, 1'b1);
        check("wr_setup_penable", PENABLE, 1'b0);
        check("wr_paddr", PADDR, 16'h0024);
        check("wr_pwdata", PWDATA, 32'h5);
        check("wr_pwrite", PWRITE, 1'b1);
        wait_rsp(n0 + 1);
        check("wr_latency", rsp_t_last - t, 20);
        repeat (2) @(posedge PCLK);
        #1;
        check("wr_psel_cycles", psel_cnt - p0, 2);
        check("wr_penable_cycles", pen_cnt - e0, 1);

        // read with 2 wait states
        waits = 2; slave_rdata = 32'h0000_0003;
        p0 = psel_cnt; e0 = pen_cnt; n0 = rsp_cnt;
        exp_q.push_back({1'b0, 32'h0000_0003});
        send(1'b0, 16'h0027, 32'hDEAD_BEEF, t);
        check("rd_paddr", PADDR, 16'h0027);
        check("rd_pwdata_zero", PWDATA, 32'h0);
        check("rd_pwrite", PWRITE, 1'b0);
        wait_rsp(n0 + 1);
        check("rd_latency", rsp_t_last - t, 40);
        repeat (2) @(posedge PCLK);
        #1;
        check("rd_access_cycles", pen_cnt - e0, 3);
        check("rd_psel_cycles", psel_cnt - p0, 4);
        waits = 0;

        // back-to-back writes
        p0 = psel_cnt; n0 = rsp_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 32'h0});
            send(1'b1, 16'h0100 + 16'(i), 32'(i + 1), ta[i]);
        end
        wait_rsp(n0 + 4);
        repeat (2) @(posedge PCLK);
        #1;
        for (int i = 1; i < 4; i++) check("b2b_period", ta[i] - ta[i-1], 30);
        check("b2b_psel_cycles", psel_cnt - p0, 8);

        // response stall
        rsp_ready = 1'b0;
        slave_rdata = 32'hA5A5_1234;
        n0 = rsp_cnt;
        exp_q.push_back({1'b0, 32'hA5A5_1234});
        send(1'b0, 16'h0030, 32'h0, t);
        wait_rsp(n0 + 1);
        slave_rdata = 32'h0BAD_0BAD;
        p0 = psel_cnt;
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_rdata", rsp_rdata, 32'hA5A5_1234);
            check("stall_req_ready", req_ready, 1'b0);
            @(posedge PCLK); #1;
        end
        check("stall_no_psel", psel_cnt - p0, 0);
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        check("stall_released", rsp_valid, 1'b0);
        check("stall_scoreboard_empty", exp_q.size(), 0);

        // PREADY stuck low -> timeout
        stuck = 1'b1; slave_rdata = 32'h1111_1111;
        e0 = pen_cnt; n0 = rsp_cnt;
        exp_q.push_back({1'b1, 32'h0});
        send(1'b0, 16'h0040, 32'h0, t);
        wait_rsp(n0 + 1);
        check("to_latency", rsp_t_last - t, 170);
        repeat (2) @(posedge PCLK);
        #1;
        check("to_access_cycles", pen_cnt - e0, 16);
        stuck = 1'b0;

        // normal read after timeout
        slave_rdata = 32'h0000_0077;
        n0 = rsp_cnt;
        exp_q.push_back({1'b0, 32'h0000_0077});
        send(1'b0, 16'h0044, 32'h0, t);
        wait_rsp(n0 + 1);
        check("post_to_latency", rsp_t_last - t, 20);
        repeat (2) @(posedge PCLK);
        #1;

        // reset mid-ACCESS
        stuck = 1'b1;
        n0 = rsp_cnt;
        send(1'b0, 16'h0050, 32'h0, t);
        repeat (3) @(posedge PCLK);
        #2;
        check("mid_access_penable", PENABLE, 1'b1);
        PRESETn = 1'b0;
        #1;
        check("arst_psel", PSEL, 1'b0);
        check("arst_penable", PENABLE, 1'b0);
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_paddr", PADDR, 16'h0);
        check("arst_req_ready", req_ready, 1'b0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        stuck = 1'b0;
        repeat (10) @(posedge PCLK);
        #1;
        check("arst_no_rsp", rsp_cnt - n0, 0);
        n0 = rsp_cnt;
        exp_q.push_back({1'b0, 32'h0});
        send(1'b1, 16'h0060, 32'h0000_0099, t);
        check("post_rst_paddr", PADDR, 16'h0060);
        check("post_rst_pwdata", PWDATA, 32'h99);
        wait_rsp(n0 + 1);
        check("post_rst_latency", rsp_t_last - t, 20);
        repeat (3) @(posedge PCLK);
        #1;
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
